// File: rtl/i2s_tx_fifo.sv
// Stereo I2S / left-justified serial transmitter fed by a small stereo sample FIFO.
// Optional macro I2S_TX_HOLD_ON_UNDERFLOW_EN repeats the last pair on underflow instead of zeros.
module i2s_tx_fifo #(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned JUSTIFY    = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [SAMPLE_W-1:0]           sample_l_i,
    input  logic [SAMPLE_W-1:0]           sample_r_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          enable_i,
    output logic                          bclk_o,
    output logic                          lrclk_o,
    output logic                          sdata_o,
    output logic                          underflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int unsigned D    = (JUSTIFY == 0) ? 1 : 0;
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CntW = $clog2(2 * SLOT_W);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    localparam logic [DivW-1:0]     DivLast = DivW'(CLK_DIV - 1);
    localparam logic [CntW-1:0]     BitLast = CntW'(2 * SLOT_W - 1);
    localparam logic [CntW-1:0]     SlotK   = CntW'(SLOT_W);
    localparam logic [CntW-1:0]     DK      = CntW'(D);
    localparam logic [CntW-1:0]     SampK   = CntW'(SAMPLE_W);
    localparam logic [LvlW-1:0]     LvlFull = LvlW'(FIFO_DEPTH);
    localparam logic [SAMPLE_W-1:0] MsbOne  = SAMPLE_W'(1) << (SAMPLE_W - 1);

    if (SAMPLE_W + D > SLOT_W) begin : g_bad_width
        $fatal(1, "i2s_tx_fifo: SAMPLE_W plus I2S delay bit exceeds SLOT_W");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $fatal(1, "i2s_tx_fifo: CLK_DIV must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "i2s_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end

    logic [2*SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]       level_q;
    logic                  full, empty, push, pop;

    logic [DivW-1:0]       div_cnt_q;
    logic [CntW-1:0]       bit_cnt_q;
    logic                  bclk_q, lrclk_q, sdata_q, uf_q;
    logic [2*SAMPLE_W-1:0] frame_q, frame_d;

    logic                  tick, fall, frame_start, is_r, bit_d;
    logic [CntW-1:0]       k, s, p;
    logic [SAMPLE_W-1:0]   chan;

    always_comb begin
        full        = (level_q == LvlFull);
        empty       = (level_q == '0);
        tick        = enable_i && (div_cnt_q == DivLast);
        fall        = tick && bclk_q;
        k           = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + 1'b1;
        frame_start = fall && (k == '0);
        push        = in_valid_i && !full;
        pop         = frame_start && !empty;

        frame_d = frame_q;
        if (frame_start) begin
            if (!empty) begin
                frame_d = mem_q[rd_ptr_q];
            end else begin
`ifdef I2S_TX_HOLD_ON_UNDERFLOW_EN
                frame_d = frame_q;
`else
                frame_d = '0;
`endif
            end
        end

        // Map the bit index being entered onto a sample bit or a padding zero.
        is_r  = (k >= SlotK);
        s     = is_r ? k - SlotK : k;
        p     = s - DK;
        chan  = is_r ? frame_d[SAMPLE_W-1:0] : frame_d[2*SAMPLE_W-1:SAMPLE_W];
        bit_d = (s >= DK) && (p < SampK) && (|(chan & (MsbOne >> p)));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {sample_l_i, sample_r_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            bit_cnt_q <= BitLast;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            uf_q      <= 1'b0;
            frame_q   <= '0;
        end else begin
            uf_q <= frame_start && empty;
            if (!enable_i) begin
                div_cnt_q <= '0;
                bit_cnt_q <= BitLast;
                bclk_q    <= 1'b0;
                lrclk_q   <= 1'b0;
                sdata_q   <= 1'b0;
            end else begin
                div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
                if (tick) bclk_q <= !bclk_q;
                if (fall) begin
                    bit_cnt_q <= k;
                    lrclk_q   <= is_r;
                    sdata_q   <= bit_d;
                    frame_q   <= frame_d;
                end
            end
        end
    end

    assign in_ready_o   = !full;
    assign bclk_o       = bclk_q;
    assign lrclk_o      = lrclk_q;
    assign sdata_o      = sdata_q;
    assign underflow_o  = uf_q;
    assign fifo_level_o = level_q;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Directed bench for i2s_tx_fifo: default I2S instance plus a 24-bit left-justified instance.
module tb_i2s_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [15:0] sl, sr;
    logic        valid, enable;
    logic        in_ready, bclk, lrclk, sdata, underflow;
    logic [2:0]  level;

    logic [23:0] lj_l, lj_r;
    logic        lj_valid, lj_enable;
    logic        lj_ready, lj_bclk, lj_lrclk, lj_sdata, lj_uf;
    logic [2:0]  lj_level;

    int   checks = 0;
    int   errors = 0;
    int   uf_cnt = 0;
    int   uf_bad = 0;
    logic bclk_pn = 1'b0;
    logic sel_lj = 1'b0;
    logic mb, ml, ms;

    assign mb = sel_lj ? lj_bclk  : bclk;
    assign ml = sel_lj ? lj_lrclk : lrclk;
    assign ms = sel_lj ? lj_sdata : sdata;

    i2s_tx_fifo dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_l_i   (sl),
        .sample_r_i   (sr),
        .in_valid_i   (valid),
        .in_ready_o   (in_ready),
        .enable_i     (enable),
        .bclk_o       (bclk),
        .lrclk_o      (lrclk),
        .sdata_o      (sdata),
        .underflow_o  (underflow),
        .fifo_level_o (level)
    );

    i2s_tx_fifo #(
        .SAMPLE_W (24),
        .SLOT_W   (24),
        .CLK_DIV  (2),
        .JUSTIFY  (1)
    ) dut_lj (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_l_i   (lj_l),
        .sample_r_i   (lj_r),
        .in_valid_i   (lj_valid),
        .in_ready_o   (lj_ready),
        .enable_i     (lj_enable),
        .bclk_o       (lj_bclk),
        .lrclk_o      (lj_lrclk),
        .sdata_o      (lj_sdata),
        .underflow_o  (lj_uf),
        .fifo_level_o (lj_level)
    );

    // Underflow pulses must land on the clk where bclk falls.
    always @(negedge clk) begin
        if (underflow === 1'b1) begin
            uf_cnt = uf_cnt + 1;
            if (!(bclk_pn === 1'b1 && bclk === 1'b0)) uf_bad = uf_bad + 1;
        end
        bclk_pn = bclk;
    end

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; valid = 1'b0; lj_enable = 1'b0; lj_valid = 1'b0;
        sl = '0; sr = '0; lj_l = '0; lj_r = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        int n = 0;
        sl = l; sr = r; valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL push_timeout: in_ready=%b after %0d clk, required 1", in_ready, n);
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic next_rise(output int g);
        logic last, cur;
        last = mb; g = 0;
        forever begin
            @(negedge clk); g++; cur = mb;
            if (!last && cur) break;
            last = cur;
            if (g > 1000) begin
                checks++; errors++;
                $display("FAIL rise_timeout: no bclk rise in %0d clk, required a rise", g);
                g = -1;
                break;
            end
        end
    endtask

    task automatic wait_fall(output int g);
        logic last, cur;
        last = mb; g = 0;
        forever begin
            @(negedge clk); g++; cur = mb;
            if (last && !cur) break;
            last = cur;
            if (g > 1000) begin
                checks++; errors++;
                $display("FAIL fall_timeout: no bclk fall in %0d clk, required a fall", g);
                g = -1;
                break;
            end
        end
    endtask

    task automatic capture(input int n, output logic [191:0] d, output logic [191:0] l,
                           output int gap);
        int g;
        d = '0; l = '0; gap = 0;
        for (int i = 0; i < n; i++) begin
            next_rise(g);
            if (g < 0) break;
            d = {d[190:0], ms};
            l = {l[190:0], ml};
            if (i == 1) gap = g;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bclk !== 1'b0) begin errors++; $display("FAIL rst_bclk: got %b want 0", bclk); end
        checks++; if (lrclk !== 1'b0) begin errors++; $display("FAIL rst_lrclk: got %b want 0", lrclk); end
        checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL rst_sdata: got %b want 0", sdata); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst_uf: got %b want 0", underflow); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", level); end
    endtask

    task automatic test_frame();
        logic [191:0] d, l;
        int n, gap;
        do_reset();
        push(16'hA5F0, 16'h0F0F);
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL frm_preload: level %0d want 1", level); end
        enable = 1'b1;
        wait_fall(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL frm_start_lat: %0d clk want 32", n); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL frm_pop: level %0d want 0", level); end
        capture(64, d, l, gap);
        checks++; if (gap !== 32) begin errors++; $display("FAIL frm_bclk_period: %0d want 32", gap); end
        checks++;
        if (d[63:0] !== 64'h52F80000_07878000) begin
            errors++; $display("FAIL frm_data: got %h want 52f8000007878000", d[63:0]);
        end
        checks++;
        if (l[63:0] !== 64'h00000000_FFFFFFFF) begin
            errors++; $display("FAIL frm_lrclk: got %h want 00000000ffffffff", l[63:0]);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++; if ({bclk, lrclk, sdata} !== 3'b000) begin
            errors++; $display("FAIL frm_idle: bclk/lrclk/sdata %b want 000", {bclk, lrclk, sdata});
        end
    endtask

    task automatic test_backpressure();
        logic [191:0] d, l;
        int n, gap;
        do_reset();
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        push(16'h5555, 16'h6666);
        push(16'h7777, 16'h8888);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level_full: %0d want 4", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: %b want 0", in_ready); end
        sl = 16'h9999; sr = 16'hAAAA; valid = 1'b1;
        @(negedge clk);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_held: level %0d want 4", level); end
        enable = 1'b1;
        wait_fall(n);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_pop: %b want 1", in_ready); end
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL bp_level_pop: %0d want 3", level); end
        @(negedge clk);
        valid = 1'b0;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_fifth: level %0d want 4", level); end
        capture(64, d, l, gap);
        checks++;
        if (d[63:0] !== 64'h08888000_11110000) begin
            errors++; $display("FAIL bp_data: got %h want 0888800011110000", d[63:0]);
        end
        enable = 1'b0;
    endtask

    task automatic test_underflow();
        logic [191:0] d, l;
        int n, gap, base;
        do_reset();
        base = uf_cnt;
        enable = 1'b1;
        wait_fall(n);
        capture(192, d, l, gap);
        enable = 1'b0;
        @(negedge clk);
        checks++; if (d !== 192'd0) begin errors++; $display("FAIL uf_zero: got %h want 0", d); end
        checks++; if (uf_cnt - base !== 3) begin errors++; $display("FAIL uf_count: %0d want 3", uf_cnt - base); end
        checks++; if (uf_bad !== 0) begin errors++; $display("FAIL uf_align: %0d misaligned want 0", uf_bad); end
    endtask

    task automatic test_hold();
        logic [191:0] d, l;
        logic [63:0] fr, rep;
        int n, gap, base;
        fr = 64'h091A0000_40008000;
`ifdef I2S_TX_HOLD_ON_UNDERFLOW_EN
        rep = fr;
`else
        rep = 64'd0;
`endif
        do_reset();
        push(16'h1234, 16'h8001);
        base = uf_cnt;
        enable = 1'b1;
        wait_fall(n);
        capture(192, d, l, gap);
        enable = 1'b0;
        @(negedge clk);
        checks++; if (d[191:128] !== fr) begin errors++; $display("FAIL hold_f0: got %h want %h", d[191:128], fr); end
        checks++; if (d[127:64] !== rep) begin errors++; $display("FAIL hold_f1: got %h want %h", d[127:64], rep); end
        checks++; if (d[63:0] !== rep) begin errors++; $display("FAIL hold_f2: got %h want %h", d[63:0], rep); end
        checks++; if (uf_cnt - base !== 2) begin errors++; $display("FAIL hold_uf: %0d want 2", uf_cnt - base); end
    endtask

    task automatic test_left_justify();
        logic [191:0] d, l;
        int n, gap;
        do_reset();
        sel_lj = 1'b1;
        lj_l = 24'h800001; lj_r = 24'hC00003; lj_valid = 1'b1;
        repeat (2) @(negedge clk);
        lj_valid = 1'b0;
        checks++; if (lj_level !== 3'd2) begin errors++; $display("FAIL lj_level: %0d want 2", lj_level); end
        lj_enable = 1'b1;
        wait_fall(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL lj_start_lat: %0d want 4", n); end
        checks++; if ({ml, ms} !== 2'b01) begin errors++; $display("FAIL lj_msb0: lr/sd %b want 01", {ml, ms}); end
        capture(48, d, l, gap);
        checks++; if (gap !== 4) begin errors++; $display("FAIL lj_period: %0d want 4", gap); end
        checks++;
        if (d[47:0] !== 48'h800001_C00003) begin
            errors++; $display("FAIL lj_data: got %h want 800001c00003", d[47:0]);
        end
        checks++;
        if (l[47:0] !== 48'h000000_FFFFFF) begin
            errors++; $display("FAIL lj_lrclk: got %h want 000000ffffff", l[47:0]);
        end
        checks++; if (ml !== 1'b1) begin errors++; $display("FAIL lj_lr_before: %b want 1", ml); end
        wait_fall(n);
        checks++; if ({ml, ms} !== 2'b01) begin errors++; $display("FAIL lj_msb1: lr/sd %b want 01", {ml, ms}); end
        lj_enable = 1'b0;
        sel_lj = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [191:0] d, l;
        int n, gap, base;
        do_reset();
        push(16'h1357, 16'h2468);
        push(16'h9ABC, 16'hDEF0);
        enable = 1'b1;
        wait_fall(n);
        base = uf_cnt;
        capture(64, d, l, gap);
        checks++;
        if (d[63:0] !== 64'h09AB8000_12340000) begin
            errors++; $display("FAIL b2b_a: got %h want 09ab800012340000", d[63:0]);
        end
        repeat (15) @(negedge clk);
        sl = 16'h4321; sr = 16'h8765; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        checks++; if (bclk !== 1'b0) begin errors++; $display("FAIL b2b_fall: bclk %b want 0", bclk); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_level: %0d want 1", level); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL b2b_uf: %b want 0", underflow); end
        capture(128, d, l, gap);
        enable = 1'b0;
        checks++;
        if (d[127:64] !== 64'h4D5E0000_6F780000) begin
            errors++; $display("FAIL b2b_b: got %h want 4d5e00006f780000", d[127:64]);
        end
        checks++;
        if (d[63:0] !== 64'h21908000_43B28000) begin
            errors++; $display("FAIL b2b_c: got %h want 2190800043b28000", d[63:0]);
        end
        checks++; if (uf_cnt !== base) begin errors++; $display("FAIL b2b_uf_cnt: %0d want %0d", uf_cnt, base); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        push(16'h0001, 16'h8000);
        push(16'h0002, 16'h0003);
        enable = 1'b1;
        wait_fall(n);
        repeat (33 * 32 + 20) @(negedge clk);
        checks++; if ({bclk, lrclk, sdata} !== 3'b111) begin
            errors++; $display("FAIL mid_pre: bclk/lrclk/sdata %b want 111", {bclk, lrclk, sdata});
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (bclk !== 1'b0) begin errors++; $display("FAIL mid_bclk: %b want 0", bclk); end
        checks++; if (lrclk !== 1'b0) begin errors++; $display("FAIL mid_lrclk: %b want 0", lrclk); end
        checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL mid_sdata: %b want 0", sdata); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL mid_uf: %b want 0", underflow); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: %b want 1", in_ready); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_level: %0d want 0", level); end
        reset_n = 1'b1;
        enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_underflow();
        test_hold();
        test_left_justify();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
